if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the RV32IM pipeline; the producer side of the IF/ID pipeline register.
- Owns the PC and runs a request/busywait handshake with the instruction memory/cache.
- Presents IF_PC / IF_INSTRUCTION to IF/ID, honours the pipeline HOLD, and squashes in-flight fetches on a taken branch/jump redirect from EX.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset
NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0) presented when no valid fetch

Ports:
CLK  input  1  clock, all state updates on posedge
RESET  input  1  synchronous, active-high reset
HOLD  input  1  downstream stall; IF/ID is not capturing this cycle
BRANCH_TAKEN  input  1  redirect request from EX
BRANCH_TARGET  input  32  redirect address; bits [1:0] ignored (treated as 00)
IMEM_READ  output  1  instruction memory read request
IMEM_ADDR  output  32  instruction memory address
IMEM_READDATA  input  32  instruction word; valid in a cycle where IMEM_READ=1 and IMEM_BUSYWAIT=0
IMEM_BUSYWAIT  input  1  memory not ready; request must be held stable while high
IF_PC  output  32  PC of the presented instruction
IF_INSTRUCTION  output  32  presented instruction, or NOP_INSTR
IF_VALID  output  1  IF_INSTRUCTION is a real fetched instruction

Behaviour:
- Registers:
  - PC: next fetch address.
  - REQ_ADDR: address of the outstanding request.
  - BUF_INSTR / BUF_PC: held instruction and its PC.
  - STATE: FETCH, HELD or DRAIN.
- Reset (RESET=1 at posedge): PC=RESET_PC, REQ_ADDR=RESET_PC, BUF_INSTR=NOP_INSTR, BUF_PC=0, STATE=FETCH.
- While RESET is high, IMEM_READ=0, IF_VALID=0, IF_INSTRUCTION=NOP_INSTR and IF_PC=PC.
- Completion: a cycle in FETCH with IMEM_READ=1 and IMEM_BUSYWAIT=0. IMEM_READDATA is sampled in that same cycle.
- Output path: outputs are combinational from STATE, buffers and IMEM_READDATA. Zero added latency, so an instruction is presented in its completion cycle.
- FETCH:
  - Drive IMEM_READ=1 and IMEM_ADDR=PC.
  - REQ_ADDR<=PC every FETCH cycle.
  - Not complete: IF_VALID=0, IF_INSTRUCTION=NOP_INSTR, IF_PC=PC; state unchanged.
  - Complete and HOLD=0: IF_VALID=1, IF_INSTRUCTION=IMEM_READDATA, IF_PC=PC. At the edge PC<=PC+4 (mod 2^32; 0xFFFFFFFC wraps to 0x00000000). Stay in FETCH.
  - Complete and HOLD=1: still present the instruction with IF_VALID=1. Capture BUF_INSTR<=IMEM_READDATA, BUF_PC<=PC, PC<=PC+4; go to HELD.
- HELD:
  - IMEM_READ=0. Present BUF_INSTR / BUF_PC with IF_VALID=1.
  - HOLD=0: IF/ID captures the buffer at this edge; go to FETCH.
  - HOLD=1: outputs stay stable.
- DRAIN (a redirect arrived while a request was outstanding; memory cannot abort):
  - IMEM_READ=1, IMEM_ADDR=REQ_ADDR, held stable.
  - IF_VALID=0, IF_INSTRUCTION=NOP_INSTR.
  - When IMEM_BUSYWAIT=0, discard the data and go to FETCH (PC already holds the target).
- Redirect (BRANCH_TAKEN=1) overrides HOLD and any completion:
  - Always: PC<={BRANCH_TARGET[31:2],2'b00}. IF_VALID=0 and IF_INSTRUCTION=NOP_INSTR in that cycle (squash, including a same-cycle completion).
  - FETCH with IMEM_BUSYWAIT=1: go to DRAIN (REQ_ADDR keeps the old address).
  - FETCH with completion: data discarded; stay in FETCH.
  - HELD: buffer discarded; go to FETCH.
  - DRAIN: PC updated to the newest target; stay in DRAIN until busywait drops.
- HOLD with no completion has no effect on fetch progress. The bubble is presented and IF/ID ignores it.
- Reset mid-DRAIN or mid-HELD: immediate return to the reset state. IMEM_READ drops in the reset cycle, and the memory side is expected to be reset together.
- No X propagation: IF_INSTRUCTION is never driven from IMEM_READDATA outside a completion cycle.

Test Plan:
- Zero-wait memory, HOLD=0, reset then run 4 cycles -> IF_PC 0x0,0x4,0x8,0xC with IF_VALID=1 each cycle; IMEM_ADDR tracks PC.
- IMEM_BUSYWAIT high 3 cycles for address 0x8 -> 3 cycles IF_VALID=0, IF_INSTRUCTION=0x00000013, IMEM_ADDR stable 0x8; the 4th cycle presents the instruction at PC 0x8.
- Completion at PC 0x10 with HOLD=1 for 2 cycles -> STATE HELD, IMEM_READ=0, IF_PC=0x10 and the instruction stable; after HOLD falls, the next fetch is 0x14.
- BRANCH_TAKEN with target 0x100 while a fetch of 0x20 is busy for 2 more cycles -> IMEM_ADDR stays 0x20 until busywait drops, data discarded (IF_VALID=0), next IMEM_ADDR=0x100; target 0x103 also yields 0x100.
- BRANCH_TAKEN in the same cycle as a completion at 0x40 with target 0x200 -> that cycle IF_VALID=0; the next fetch is 0x200, not 0x44.
- RESET_PC=0xFFFFFFFC with zero-wait memory -> second fetch at 0x00000000. Separately, RESET asserted in DRAIN -> next cycle STATE=FETCH, IMEM_ADDR=RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the request/busywait handshake with
// instruction memory and presents fetched words to the IF/ID register.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        HOLD,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    output logic        IMEM_READ,
    output logic [31:0] IMEM_ADDR,
    input  logic [31:0] IMEM_READDATA,
    input  logic        IMEM_BUSYWAIT,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_INSTRUCTION,
    output logic        IF_VALID
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HELD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] req_addr;
    logic [31:0] buf_instr;
    logic [31:0] buf_pc;
    logic [31:0] target;
    logic        complete;

    assign target   = {BRANCH_TARGET[31:2], 2'b00};
    assign complete = !RESET && (state == FETCH) && !IMEM_BUSYWAIT;

    always_comb begin
        IMEM_READ      = 1'b0;
        IMEM_ADDR      = pc;
        IF_PC          = pc;
        IF_INSTRUCTION = NOP_INSTR;
        IF_VALID       = 1'b0;
        if (!RESET) begin
            case (state)
                FETCH: begin
                    IMEM_READ = 1'b1;
                    if (complete && !BRANCH_TAKEN) begin
                        IF_VALID       = 1'b1;
                        IF_INSTRUCTION = IMEM_READDATA;
                    end
                end
                HELD: begin
                    IF_PC = buf_pc;
                    if (!BRANCH_TAKEN) begin
                        IF_VALID       = 1'b1;
                        IF_INSTRUCTION = buf_instr;
                    end
                end
                DRAIN: begin
                    IMEM_READ = 1'b1;
                    IMEM_ADDR = req_addr;
                end
                default: begin
                    IMEM_READ = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            req_addr  <= RESET_PC;
            buf_instr <= NOP_INSTR;
            buf_pc    <= '0;
        end else begin
            case (state)
                FETCH: begin
                    // req_addr takes the pre-redirect PC, so a squashed busy
                    // request is drained at the address memory is working on.
                    req_addr <= pc;
                    if (BRANCH_TAKEN) begin
                        pc <= target;
                        if (IMEM_BUSYWAIT) state <= DRAIN;
                    end else if (!IMEM_BUSYWAIT) begin
                        pc <= pc + 32'd4;
                        if (HOLD) begin
                            buf_instr <= IMEM_READDATA;
                            buf_pc    <= pc;
                            state     <= HELD;
                        end
                    end
                end
                HELD: begin
                    if (BRANCH_TAKEN) begin
                        pc    <= target;
                        state <= FETCH;
                    end else if (!HOLD) begin
                        state <= FETCH;
                    end
                end
                DRAIN: begin
                    if (BRANCH_TAKEN) pc <= target;
                    if (!IMEM_BUSYWAIT) state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: sequential fetch, busywait, hold, redirect,
// drain, PC wrap and reset-in-drain.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, hold, branch_taken, busywait;
    logic [31:0] branch_target;
    logic        imem_read, imem_read_w;
    logic [31:0] imem_addr, imem_addr_w, readdata, readdata_w;
    logic [31:0] if_pc, if_pc_w, if_instr, if_instr_w;
    logic        if_valid, if_valid_w;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[15:0]};
    endfunction

    assign readdata   = mem(imem_addr);
    assign readdata_w = mem(imem_addr_w);

    if_fetch_unit dut (
        .CLK(clk), .RESET(reset), .HOLD(hold),
        .BRANCH_TAKEN(branch_taken), .BRANCH_TARGET(branch_target),
        .IMEM_READ(imem_read), .IMEM_ADDR(imem_addr),
        .IMEM_READDATA(readdata), .IMEM_BUSYWAIT(busywait),
        .IF_PC(if_pc), .IF_INSTRUCTION(if_instr), .IF_VALID(if_valid)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .CLK(clk), .RESET(reset), .HOLD(hold),
        .BRANCH_TAKEN(branch_taken), .BRANCH_TARGET(branch_target),
        .IMEM_READ(imem_read_w), .IMEM_ADDR(imem_addr_w),
        .IMEM_READDATA(readdata_w), .IMEM_BUSYWAIT(busywait),
        .IF_PC(if_pc_w), .IF_INSTRUCTION(if_instr_w), .IF_VALID(if_valid_w)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks a presented valid instruction fetched at address a
    task automatic chk_fetch(input string tag, input logic [31:0] a);
        #1;
        chk({tag, ".read"}, 32'(imem_read), 32'd1);
        chk({tag, ".addr"}, imem_addr, a);
        chk({tag, ".valid"}, 32'(if_valid), 32'd1);
        chk({tag, ".pc"}, if_pc, a);
        chk({tag, ".instr"}, if_instr, mem(a));
    endtask

    task automatic chk_bubble(input string tag, input logic read, input logic [31:0] a);
        #1;
        chk({tag, ".read"}, 32'(imem_read), 32'(read));
        if (read) chk({tag, ".addr"}, imem_addr, a);
        chk({tag, ".valid"}, 32'(if_valid), 32'd0);
        chk({tag, ".instr"}, if_instr, NOP);
    endtask

    task automatic do_reset();
        reset = 1'b1; hold = 1'b0; branch_taken = 1'b0; busywait = 1'b0;
        branch_target = '0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; hold = 1'b0; branch_taken = 1'b0; busywait = 1'b0;
        branch_target = '0;
        tick();
        #1;
        chk("rst.read", 32'(imem_read), 32'd0);
        chk("rst.valid", 32'(if_valid), 32'd0);
        chk("rst.instr", if_instr, NOP);
        chk("rst.pc", if_pc, 32'h0);
        chk("rst_w.pc", if_pc_w, 32'hFFFF_FFFC);
        tick();
        reset = 1'b0;

        // Zero-wait sequential fetch, plus wrap on the high-reset instance
        chk_fetch("seq0", 32'h0);
        chk("wrap0.pc", if_pc_w, 32'hFFFF_FFFC);
        chk("wrap0.valid", 32'(if_valid_w), 32'd1);
        tick();
        chk("wrap1.addr", imem_addr_w, 32'h0);
        chk("wrap1.pc", if_pc_w, 32'h0);
        for (int unsigned i = 1; i < 4; i++) begin
            chk_fetch("seq", 32'(i * 4));
            tick();
        end

        // Completion at 0x10 under HOLD, held two cycles, then release
        hold = 1'b1;
        chk_fetch("hold.c", 32'h10);
        tick();
        for (int unsigned i = 0; i < 2; i++) begin
            #1;
            chk("held.read", 32'(imem_read), 32'd0);
            chk("held.valid", 32'(if_valid), 32'd1);
            chk("held.pc", if_pc, 32'h10);
            chk("held.instr", if_instr, mem(32'h10));
            tick();
        end
        hold = 1'b0;
        #1;
        chk("rel.read", 32'(imem_read), 32'd0);
        chk("rel.pc", if_pc, 32'h10);
        chk("rel.valid", 32'(if_valid), 32'd1);
        tick();
        chk_fetch("after_hold", 32'h14);
        tick();

        // Busywait three cycles at 0x8
        do_reset();
        chk_fetch("bw0", 32'h0);
        tick();
        chk_fetch("bw4", 32'h4);
        tick();
        busywait = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            chk_bubble("busy", 1'b1, 32'h8);
            tick();
        end
        busywait = 1'b0;
        chk_fetch("bw8", 32'h8);
        tick();
        chk_fetch("bwC", 32'hC);
        tick();

        // Redirect during busy fetch at 0x10, re-redirect in DRAIN to 0x103
        busywait = 1'b1;
        chk_bubble("br.busy", 1'b1, 32'h10);
        tick();
        branch_taken = 1'b1; branch_target = 32'h300;
        chk_bubble("br.sq", 1'b1, 32'h10);
        tick();
        branch_target = 32'h103;
        chk_bubble("drain1", 1'b1, 32'h10);
        tick();
        branch_taken = 1'b0;
        chk_bubble("drain2", 1'b1, 32'h10);
        tick();
        busywait = 1'b0;
        chk_bubble("drain.end", 1'b1, 32'h10);
        tick();
        chk_fetch("br.tgt", 32'h100);
        tick();

        // Redirect coinciding with completion at 0x40
        do_reset();
        for (int unsigned i = 0; i < 16; i++) tick();
        #1;
        chk("pre40.addr", imem_addr, 32'h40);
        branch_taken = 1'b1; branch_target = 32'h200;
        chk_bubble("sq40", 1'b1, 32'h40);
        tick();
        branch_taken = 1'b0;
        chk_fetch("tgt200", 32'h200);
        tick();

        // Reset asserted while draining
        busywait = 1'b1; branch_taken = 1'b1; branch_target = 32'h80;
        chk_bubble("rd.sq", 1'b1, 32'h204);
        tick();
        branch_taken = 1'b0;
        chk_bubble("rd.drain", 1'b1, 32'h204);
        reset = 1'b1;
        chk_bubble("rd.rst", 1'b0, 32'h0);
        tick();
        reset = 1'b0; busywait = 1'b0;
        chk_fetch("rd.after", 32'h0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
